// File: rtl/complete_stage.sv
// complete_stage: reorder-buffer bookkeeping for 2-wide dispatch, 3-wide completion broadcast and 2-wide in-order retire.
// Define COMPLETE_STAGE_BYPASS_EN to let results arriving on an edge count as complete in that same edge's retire check.
module complete_stage #(
    parameter int  ROB_DEPTH = 16,
    parameter int  P_REG_W   = 6,
    parameter type rob_row_struct = struct packed {
        logic                         valid;
        logic [$clog2(ROB_DEPTH)-1:0] rob_tag;
        logic [P_REG_W-1:0]           PRegAddrDst;
        logic [31:0]                  data;
        logic                         RegWrite;
        logic                         MemWrite;
        logic                         complete;
    },
    parameter type complete_stage_struct = struct packed {
        logic                         valid;
        logic [$clog2(ROB_DEPTH)-1:0] rob_tag;
        logic [31:0]                  data;
    }
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  rob_row_struct        i_rob_row           [0:1],
    input  complete_stage_struct i_complete_result   [0:2],
    output rob_row_struct        o_complete_rob_rows [0:2],
    output rob_row_struct        o_retire_rob_rows   [0:1],
    output logic                 o_full
);

    localparam int TW = $clog2(ROB_DEPTH);
    localparam int CW = TW + 1;

    rob_row_struct entry_q  [0:ROB_DEPTH-1];
    rob_row_struct entry_d  [0:ROB_DEPTH-1];
    rob_row_struct resView  [0:ROB_DEPTH-1];
    rob_row_struct retView  [0:ROB_DEPTH-1];
    rob_row_struct allocRow [0:1];
    logic          allocEn  [0:1];
    rob_row_struct cmpl_q   [0:2];
    rob_row_struct cmpl_d   [0:2];
    rob_row_struct ret_q    [0:1];
    rob_row_struct ret_d    [0:1];

    logic [TW-1:0] head_q;
    logic [TW-1:0] head_d;
    logic [TW-1:0] headNext;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full;
    logic          ret0;
    logic          ret1;
    logic [1:0]    nAlloc;
    logic [1:0]    nRet;

    assign full     = count_q > CW'(ROB_DEPTH - 2);
    assign headNext = head_q + TW'(1);

    // Results land only on live entries, or on a tag being allocated on the same edge; the higher result index wins.
    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            resView[i] = entry_q[i];
        end
        for (int k = 0; k < 3; k++) begin
            cmpl_d[k] = '0;
        end
        nAlloc = '0;

        for (int k = 0; k < 3; k++) begin
            if (i_complete_result[k].valid && entry_q[i_complete_result[k].rob_tag].valid) begin
                resView[i_complete_result[k].rob_tag].complete = 1'b1;
                resView[i_complete_result[k].rob_tag].data     = i_complete_result[k].data;
                cmpl_d[k]          = entry_q[i_complete_result[k].rob_tag];
                cmpl_d[k].complete = 1'b1;
                cmpl_d[k].data     = i_complete_result[k].data;
            end
        end

        for (int r = 0; r < 2; r++) begin
            allocRow[r]          = i_rob_row[r];
            allocRow[r].valid    = 1'b1;
            allocRow[r].complete = 1'b0;
            allocEn[r]           = i_rob_row[r].valid && !full;
            if (allocEn[r]) begin
                nAlloc = nAlloc + 2'd1;
                for (int k = 0; k < 3; k++) begin
                    if (i_complete_result[k].valid &&
                        i_complete_result[k].rob_tag == i_rob_row[r].rob_tag) begin
                        allocRow[r].complete = 1'b1;
                        allocRow[r].data     = i_complete_result[k].data;
                        cmpl_d[k]            = allocRow[r];
                    end
                end
            end
        end
    end

    // Retire looks only at entries that were live before this edge; bypass adds this edge's results to that view.
    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
`ifdef COMPLETE_STAGE_BYPASS_EN
            retView[i] = resView[i];
`else
            retView[i] = entry_q[i];
`endif
        end
        ret0     = retView[head_q].valid && retView[head_q].complete;
        ret1     = ret0 && retView[headNext].valid && retView[headNext].complete;
        ret_d[0] = ret0 ? retView[head_q]   : '0;
        ret_d[1] = ret1 ? retView[headNext] : '0;
        nRet     = {1'b0, ret0} + {1'b0, ret1};
    end

    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            entry_d[i] = resView[i];
        end
        for (int r = 0; r < 2; r++) begin
            if (allocEn[r]) begin
                entry_d[allocRow[r].rob_tag] = allocRow[r];
            end
        end
        if (ret0) begin
            entry_d[head_q] = '0;
        end
        if (ret1) begin
            entry_d[headNext] = '0;
        end
        head_d  = head_q + TW'(nRet);
        count_d = count_q + CW'(nAlloc) - CW'(nRet);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                cmpl_q[k] <= '0;
            end
            ret_q[0] <= '0;
            ret_q[1] <= '0;
            head_q   <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            for (int k = 0; k < 3; k++) begin
                cmpl_q[k] <= cmpl_d[k];
            end
            ret_q[0] <= ret_d[0];
            ret_q[1] <= ret_d[1];
            head_q   <= head_d;
            count_q  <= count_d;
        end
    end

    assign o_complete_rob_rows = cmpl_q;
    assign o_retire_rob_rows   = ret_q;
    assign o_full              = full;

endmodule

// File: tb/tb_complete_stage.sv
// tb_complete_stage: directed stimulus with a queue scoreboard; a negedge monitor pops and compares every
// completion broadcast and retire row the DUT presents, including the cycle it was expected on.
module tb_complete_stage;

    localparam int ROB_DEPTH = 16;
    localparam int P_REG_W   = 6;
`ifdef COMPLETE_STAGE_BYPASS_EN
    localparam int RET_LAT = 0;
`else
    localparam int RET_LAT = 1;
`endif

    typedef struct packed {
        logic        valid;
        logic [3:0]  rob_tag;
        logic [5:0]  PRegAddrDst;
        logic [31:0] data;
        logic        RegWrite;
        logic        MemWrite;
        logic        complete;
    } row_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  rob_tag;
        logic [31:0] data;
    } res_t;

    typedef struct {
        int          cyc;
        int          slot;
        int          tag;
        logic [31:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    row_t robRow     [0:1];
    res_t result     [0:2];
    row_t cmplRows   [0:2];
    row_t retireRows [0:1];
    logic full;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t cmplQ [$];
    exp_t retQ  [$];

    complete_stage #(
        .ROB_DEPTH (ROB_DEPTH),
        .P_REG_W   (P_REG_W)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_rob_row           (robRow),
        .i_complete_result   (result),
        .o_complete_rob_rows (cmplRows),
        .o_retire_rob_rows   (retireRows),
        .o_full              (full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] pregOf(input int tag);
        return 6'((tag * 5 + 3) % 64);
    endfunction

    function automatic logic regwOf(input int tag);
        return (tag % 2) == 0;
    endfunction

    function automatic logic memwOf(input int tag);
        return (tag % 2) == 1;
    endfunction

    function automatic row_t mkRow(input int tag);
        row_t r;
        r             = '0;
        r.valid       = 1'b1;
        r.rob_tag     = 4'(tag);
        r.PRegAddrDst = pregOf(tag);
        r.data        = 32'hD000_0000 | 32'(tag);
        r.RegWrite    = regwOf(tag);
        r.MemWrite    = memwOf(tag);
        r.complete    = 1'b1;
        return r;
    endfunction

    function automatic res_t mkRes(input int tag, input logic [31:0] data);
        res_t r;
        r.valid   = 1'b1;
        r.rob_tag = 4'(tag);
        r.data    = data;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expCmpl(input int c, input int slot, input int tag, input logic [31:0] data);
        exp_t e;
        e.cyc = c; e.slot = slot; e.tag = tag; e.data = data;
        cmplQ.push_back(e);
    endtask

    task automatic expRet(input int c, input int slot, input int tag, input logic [31:0] data);
        exp_t e;
        e.cyc = c; e.slot = slot; e.tag = tag; e.data = data;
        retQ.push_back(e);
    endtask

    task automatic compareRow(input string pfx, input int slot, input int nowCyc, input row_t r, input exp_t e);
        checkOutput({pfx, "_slot"},     64'(slot),          64'(e.slot));
        checkOutput({pfx, "_cycle"},    64'(nowCyc),        64'(e.cyc));
        checkOutput({pfx, "_tag"},      64'(r.rob_tag),     64'(e.tag));
        checkOutput({pfx, "_data"},     64'(r.data),        64'(e.data));
        checkOutput({pfx, "_preg"},     64'(r.PRegAddrDst), 64'(pregOf(e.tag)));
        checkOutput({pfx, "_regwrite"}, 64'(r.RegWrite),    64'(regwOf(e.tag)));
        checkOutput({pfx, "_memwrite"}, 64'(r.MemWrite),    64'(memwOf(e.tag)));
        checkOutput({pfx, "_complete"}, 64'(r.complete),    64'(1));
    endtask

    // Monitor: every valid output row must match the oldest pending expectation for that stream.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (cmplRows[k].valid) begin
                    if (cmplQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL cmpl%0d_unexpected: actual valid tag %0d, required no output", k, cmplRows[k].rob_tag);
                    end else begin
                        compareRow($sformatf("cmpl%0d", k), k, cyc, cmplRows[k], cmplQ.pop_front());
                    end
                end
            end
            if (retireRows[1].valid && !retireRows[0].valid) begin
                checks++;
                errors++;
                $display("[TB] FAIL ret_slot_order: actual slot1 valid with slot0 invalid, required slot0 first");
            end
            for (int s = 0; s < 2; s++) begin
                if (retireRows[s].valid) begin
                    if (retQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL ret%0d_unexpected: actual valid tag %0d, required no output", s, retireRows[s].rob_tag);
                    end else begin
                        compareRow($sformatf("ret%0d", s), s, cyc, retireRows[s], retQ.pop_front());
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input row_t r0, input row_t r1, input res_t s0, input res_t s1, input res_t s2);
        robRow[0] = r0;
        robRow[1] = r1;
        result[0] = s0;
        result[1] = s1;
        result[2] = s2;
        @(posedge clk);
        #1;
        robRow[0] = '0;
        robRow[1] = '0;
        result[0] = '0;
        result[1] = '0;
        result[2] = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        cmplQ.delete();
        retQ.delete();
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("rst_cmpl%0d_row", k), 64'(cmplRows[k]), 64'(0));
        end
        checkOutput("rst_ret0_row", 64'(retireRows[0]), 64'(0));
        checkOutput("rst_ret1_row", 64'(retireRows[1]), 64'(0));
        checkOutput("rst_full",     64'(full),          64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int edgeNo;
        robRow[0] = '0;
        robRow[1] = '0;
        result[0] = '0;
        result[1] = '0;
        result[2] = '0;
        #3;
        doReset();

        // Idle after reset.
        idle(3);
        checkOutput("idle_full",        64'(full),                64'(0));
        checkOutput("idle_ret0_valid",  64'(retireRows[0].valid), 64'(0));
        checkOutput("idle_cmpl0_valid", 64'(cmplRows[0].valid),   64'(0));

        // Out-of-order completion, in-order paired retire.
        applyStimulus(mkRow(0), mkRow(1), '0, '0, '0);
        edgeNo = cyc + 1;
        expCmpl(edgeNo, 0, 1, 32'h22);
        applyStimulus('0, '0, mkRes(1, 32'h22), '0, '0);
        edgeNo = cyc + 1;
        expCmpl(edgeNo, 1, 0, 32'h11);
        expRet(edgeNo + RET_LAT, 0, 0, 32'h11);
        expRet(edgeNo + RET_LAT, 1, 1, 32'h22);
        applyStimulus('0, '0, '0, mkRes(0, 32'h11), '0);
        idle(3);

        // Completion-to-retire latency, same-edge allocate+complete, ignored and duplicate-tag results.
        doReset();
        applyStimulus(mkRow(0), '0, '0, '0, '0);
        edgeNo = cyc + 1;
        expCmpl(edgeNo, 0, 0, 32'hAB);
        expRet(edgeNo + RET_LAT, 0, 0, 32'hAB);
        applyStimulus('0, '0, mkRes(0, 32'hAB), '0, '0);
        idle(2);
        edgeNo = cyc + 1;
        expCmpl(edgeNo, 2, 1, 32'h5A);
        expRet(edgeNo + 1, 0, 1, 32'h5A);
        applyStimulus(mkRow(1), '0, '0, mkRes(5, 32'h77), mkRes(1, 32'h5A));
        idle(2);
        applyStimulus(mkRow(2), '0, '0, '0, '0);
        edgeNo = cyc + 1;
        expCmpl(edgeNo, 0, 2, 32'h100);
        expCmpl(edgeNo, 2, 2, 32'h200);
        expRet(edgeNo + RET_LAT, 0, 2, 32'h200);
        applyStimulus('0, '0, mkRes(2, 32'h100), '0, mkRes(2, 32'h200));
        idle(2);
        applyStimulus('0, '0, mkRes(0, 32'h999), '0, '0);
        idle(2);

        // Fill to full, drop allocation while full, then drain two.
        doReset();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(mkRow(2 * i), mkRow(2 * i + 1), '0, '0, '0);
        end
        checkOutput("full_at_14", 64'(full), 64'(0));
        applyStimulus(mkRow(14), '0, '0, '0, '0);
        checkOutput("full_at_15", 64'(full), 64'(1));
        applyStimulus(mkRow(15), '0, '0, '0, '0);
        checkOutput("full_after_drop", 64'(full), 64'(1));
        applyStimulus('0, '0, mkRes(15, 32'hF5), '0, '0);
        edgeNo = cyc + 1;
        expCmpl(edgeNo, 0, 0, 32'h1000);
        expCmpl(edgeNo, 1, 1, 32'h1001);
        expRet(edgeNo + RET_LAT, 0, 0, 32'h1000);
        expRet(edgeNo + RET_LAT, 1, 1, 32'h1001);
        applyStimulus('0, '0, mkRes(0, 32'h1000), mkRes(1, 32'h1001), '0);
        repeat (RET_LAT) @(posedge clk);
        #1;
        checkOutput("full_after_retire", 64'(full), 64'(0));

        // Stream pairs with concurrent retire, then wrap the tag space.
        doReset();
        for (int i = 0; i < 7; i++) begin
            edgeNo = cyc + 1;
            expCmpl(edgeNo, 0, 2 * i,     32'h2000 + 32'(2 * i));
            expCmpl(edgeNo, 1, 2 * i + 1, 32'h2000 + 32'(2 * i + 1));
            expRet(edgeNo + 1, 0, 2 * i,     32'h2000 + 32'(2 * i));
            expRet(edgeNo + 1, 1, 2 * i + 1, 32'h2000 + 32'(2 * i + 1));
            applyStimulus(mkRow(2 * i), mkRow(2 * i + 1),
                          mkRes(2 * i, 32'h2000 + 32'(2 * i)), mkRes(2 * i + 1, 32'h2000 + 32'(2 * i + 1)), '0);
        end
        applyStimulus(mkRow(14), mkRow(15), '0, '0, '0);
        applyStimulus(mkRow(0), mkRow(1), '0, '0, '0);
        checkOutput("wrap_full", 64'(full), 64'(0));
        edgeNo = cyc + 1;
        expCmpl(edgeNo, 0, 1,  32'h110);
        expCmpl(edgeNo, 2, 15, 32'h150);
        applyStimulus('0, '0, mkRes(1, 32'h110), '0, mkRes(15, 32'h150));
        edgeNo = cyc + 1;
        expCmpl(edgeNo, 0, 14, 32'h140);
        expCmpl(edgeNo, 1, 0,  32'h100);
        expRet(edgeNo + RET_LAT,     0, 14, 32'h140);
        expRet(edgeNo + RET_LAT,     1, 15, 32'h150);
        expRet(edgeNo + RET_LAT + 1, 0, 0,  32'h100);
        expRet(edgeNo + RET_LAT + 1, 1, 1,  32'h110);
        applyStimulus('0, '0, mkRes(14, 32'h140), mkRes(0, 32'h100), '0);
        idle(4);
        checkOutput("wrap_drained_full", 64'(full), 64'(0));

        // Head blocks retire until it completes; reset mid-stream clears everything at once.
        doReset();
        applyStimulus(mkRow(0), mkRow(1), '0, '0, '0);
        edgeNo = cyc + 1;
        expCmpl(edgeNo, 0, 1, 32'h31);
        applyStimulus('0, '0, mkRes(1, 32'h31), '0, '0);
        idle(3);
        edgeNo = cyc + 1;
        expCmpl(edgeNo, 1, 0, 32'h30);
        expRet(edgeNo + RET_LAT, 0, 0, 32'h30);
        expRet(edgeNo + RET_LAT, 1, 1, 32'h31);
        applyStimulus('0, '0, '0, mkRes(0, 32'h30), '0);
        idle(2);
        applyStimulus(mkRow(2), mkRow(3), '0, '0, '0);
        applyStimulus('0, '0, mkRes(3, 32'h33), '0, '0);
        doReset();
        edgeNo = cyc + 1;
        expCmpl(edgeNo, 2, 0, 32'h40);
        expRet(edgeNo + 1, 0, 0, 32'h40);
        applyStimulus(mkRow(0), '0, mkRes(2, 32'h99), '0, mkRes(0, 32'h40));
        idle(3);

        checkOutput("cmplQ_drained", 64'(cmplQ.size()), 64'(0));
        checkOutput("retQ_drained",  64'(retQ.size()),  64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: actual timeout at cycle %0d, required completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/complete_stage.md
COMPLETE_STAGE -- requirements
Module: complete_stage

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, meaning number of reorder-buffer entries (power of two, at least 4).
REQ-002 SHALL have parameter P_REG_W, default 6, meaning physical register address width.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_rob_row[0:1], input, rob_row_struct: dispatched rows. Fields: valid(1), rob_tag(log2 ROB_DEPTH), PRegAddrDst(P_REG_W), data(32), RegWrite(1), MemWrite(1), complete(1).
REQ-006 SHALL have port i_complete_result[0:2], input, complete_stage_struct: one per functional unit. Fields: valid(1), rob_tag, data(32).
REQ-007 SHALL have port o_complete_rob_rows[0:2], output, rob_row_struct: completion broadcast, one per functional unit.
REQ-008 SHALL have port o_retire_rob_rows[0:1], output, rob_row_struct: in-order retire, oldest in slot 0.
REQ-009 SHALL have port o_full, output, 1 bit: fewer than 2 free entries.

Function
REQ-010 On each edge, every valid i_rob_row[k] SHALL be written to entry[rob_tag] with complete=0; tags arrive consecutive modulo ROB_DEPTH, slot 0 older.
REQ-011 Each valid i_complete_result[k] SHALL, on the edge, set entry[rob_tag].complete=1 and entry.data=result data.
REQ-012 A result whose tag targets an invalid entry SHALL be ignored, except when that tag is allocated on the same edge; the entry is then allocated already complete with the result data.
REQ-013 o_complete_rob_rows[k] SHALL be registered, one cycle after the result: the updated entry with valid=1, complete=1, and result data. Otherwise valid=0.
REQ-014 Retire evaluation at each edge: entry[head] retires if valid and complete; entry[head+1] retires only if entry[head] retires and entry[head+1] is valid and complete. Maximum 2 per cycle.
REQ-015 Retired entries SHALL appear on o_retire_rob_rows, registered, with valid=1. Their entries are invalidated and head advances by the retire count, wrapping modulo ROB_DEPTH.
REQ-016 Unused retire slots SHALL drive valid=0. Retire slot 1 SHALL never be valid while slot 0 is invalid.
REQ-017 Occupancy count SHALL update by allocations minus retirements in the same edge. Both may occur in the same cycle.
REQ-018 o_full SHALL be 1 when count > ROB_DEPTH-2, computed from registered count.
REQ-019 Allocation while full is a caller error. The block SHALL drop the rows and leave state unchanged.
REQ-020 Multiple results with the same tag on one edge: the highest index k wins.
REQ-021 MemWrite and RegWrite SHALL pass through unmodified. data carries the store address for stores and the result for register writes.

Reset
REQ-022 While i_rst_n=0, all entries SHALL be invalid and complete=0, with head=0 and count=0.
REQ-023 While i_rst_n=0, every output row SHALL have valid=0 and all fields 0, and o_full=0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight entries immediately.
REQ-025 The first edge after release SHALL behave as normal operation.

Configuration
REQ-026 Macro COMPLETE_STAGE_BYPASS_EN SHALL control same-edge completion-to-retire bypass.
REQ-027 With COMPLETE_STAGE_BYPASS_EN defined, the retire evaluation (REQ-014) SHALL treat results arriving on that edge as complete. The retire output then appears the same cycle as the matching o_complete_rob_rows.
REQ-028 With COMPLETE_STAGE_BYPASS_EN undefined, retire SHALL use only stored completion state. Retire therefore occurs at least one cycle after the completion broadcast.

Verification
REQ-029 Scenario: reset, then idle -> all outputs valid=0, o_full=0.
REQ-030 Scenario: dispatch tags 0,1; results for tag 1 (data 0x22), then tag 0 (data 0x11) -> both retire in one cycle, slot0 data 0x11, slot1 data 0x22, in order.
REQ-031 Scenario: tag 0 completes with data 0xAB -> o_complete_rob_rows[0] valid next cycle. Retire follows the same cycle with BYPASS_EN, or one cycle later without it.
REQ-032 Scenario: dispatch 15 entries with no completions -> o_full=1. Complete and retire 2 -> o_full=0.
REQ-033 Scenario: dispatch through tag 15 and wrap to tags 0,1, completing all -> retire order 14,15,0,1; head wraps correctly.
REQ-034 Scenario: tag 0 incomplete, tag 1 complete -> no retire until tag 0 completes. Assert i_rst_n=0 mid-stream -> outputs clear immediately.
